seq_mag_comparator: RTL and testbench
=====================================

# seq_mag_comparator

Multi-cycle, parametrised magnitude comparator for wide operands. Captures two WIDTH-bit operands on a start strobe and compares them CHUNK bits per cycle, MSB chunk first, exiting early on the first differing chunk. Supports unsigned and two's-complement signed modes per operation. Produces a registered one-hot eq/lt/gt result with a done pulse, for datapaths whose operands are too wide for a single-cycle compare at the target clock.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; must be at least 1. NCHUNK = WIDTH/CHUNK.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only when idle.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned; captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- busy  out  1  high while a comparison is in progress.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- eq  out  1  a == b.
- lt  out  1  a < b.
- gt  out  1  a > b.

## Operation
- Two states: IDLE and CMP. busy = (state == CMP).
- IDLE:
  - If start = 1, register a, b and is_signed, and set chunk index idx = NCHUNK-1. Go to CMP.
  - Otherwise stay in IDLE.
- CMP, each cycle:
  - Compare chunk idx of the captured operands (bits idx*CHUNK+CHUNK-1 down to idx*CHUNK) as unsigned values.
  - Signed mode: when idx = NCHUNK-1, invert bit WIDTH-1 of both operands before the compare. This gives a correct signed ordering with no separate sign logic.
  - Chunks differ: set gt or lt by the chunk compare, clear eq. Pulse done and go to IDLE. This is the early exit.
  - Chunks equal and idx = 0: set eq = 1, clear lt and gt. Pulse done and go to IDLE.
  - Chunks equal and idx > 0: decrement idx and stay in CMP.
- eq, lt and gt change only in the cycle done is asserted.
  - After the first completed compare, exactly one of them is high.
  - They hold their value until the next done or reset.
- start while busy is ignored. Operand and mode inputs are don't-care after the capture edge.
- Reset (rst_n = 0 at a rising edge), including mid-operation:
  - state becomes IDLE.
  - busy, done, eq, lt and gt all become 0.
  - Any in-flight compare is discarded and no done is produced for it.

## Timing
- Capture edge E0: start = 1 while IDLE. busy = 1 from after E0.
- Compare of chunk NCHUNK-1-k happens at edge E(k+1).
- Completion at edge Ek, where k = number of chunks examined (1..NCHUNK):
  - done = 1 and results are valid from Ek to E(k+1).
  - busy = 0 in the same cycle.
- Latency: best case 1 cycle (top chunks differ), worst case NCHUNK cycles (equal operands, or a difference only in chunk 0).
- Back-to-back: start = 1 during the done cycle is accepted at the next edge. The next done is no earlier than 1 cycle later, so a new compare can start every NCHUNK+1 cycles worst case.
- A start sampled at the same edge as rst_n = 0 is ignored; reset wins.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=32, CHUNK=4, so NCHUNK = 8.
- Unsigned equal: a = b = 0x1234_5678, is_signed = 0 -> done exactly 8 edges after the start edge, eq=1, lt=0, gt=0. busy is high for 8 cycles.
- Early exit, unsigned: a = 0xF000_0000, b = 0x0FFF_FFFF, is_signed = 0 -> done 1 edge after start, gt=1.
- Signed flip: same operands with is_signed = 1 -> done after 1 edge, lt=1. Also a = 0xFFFF_FFFF, b = 0xFFFF_FFFE signed -> done after 8 edges, gt=1.
- Late difference: a = 0x0000_0003, b = 0x0000_0005, unsigned -> done after 8 edges, lt=1.
  - Change a and b to random values during busy; the result must be unaffected.
  - Hold start high throughout busy; there must be no restart.
- Back-to-back: assert start with new operands a = 7, b = 7 in the done cycle of the previous compare -> second compare is accepted at the next edge, and its done gives eq=1.
  - The previous result holds until that second done.
- Reset mid-op: start a = b = 0xAAAA_AAAA, then drive rst_n = 0 at the 3rd edge of busy -> busy, done, eq, lt and gt are all 0 after that edge, and no done pulse follows.
  - A subsequent start with a = 1, b = 2 gives lt=1 after 8 edges.

Source files
------------

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks the captured operands CHUNK bits per
// cycle from the MSB chunk down, stopping at the first differing chunk.
module seq_mag_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             signed_q, signed_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;

  logic [WIDTH-1:0] sign_mask, a_eff, b_eff;
  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];
  logic [CHUNK-1:0] cur_a, cur_b;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so only the top chunk needs to see it.
  assign sign_mask = (signed_q && (idx_q == TOP_IDX)) ? (WIDTH'(1) << (WIDTH - 1)) : '0;
  assign a_eff     = a_q ^ sign_mask;
  assign b_eff     = b_q ^ sign_mask;

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunk[gi] = a_eff[gi*CHUNK +: CHUNK];
      assign b_chunk[gi] = b_eff[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign cur_a = a_chunk[idx_q];
  assign cur_b = b_chunk[idx_q];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    done_d   = 1'b0;
    eq_d     = eq_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          signed_d = is_signed;
          idx_d    = TOP_IDX;
          state_d  = CMP;
        end
      end
      CMP: begin
        if (cur_a != cur_b) begin
          gt_d    = (cur_a > cur_b);
          lt_d    = (cur_a < cur_b);
          eq_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      done_q   <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      done_q   <= done_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
    end
  end

  assign busy = (state_q == CMP);
  assign done = done_q;
  assign eq   = eq_q;
  assign lt   = lt_q;
  assign gt   = gt_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator (WIDTH=32, CHUNK=4): stimulus pushes
// the expected result and completion cycle, a monitor pops on every done.
module tb_seq_mag_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] a, b;
  logic        busy, done, eq, lt, gt;

  int checks   = 0;
  int failures = 0;
  int cycle_cnt = 0;

  typedef struct {
    logic [2:0] res;   // {eq, lt, gt}
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  seq_mag_comparator #(.WIDTH(32), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .lt(lt), .gt(gt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 cycle=%0d", cycle_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_eq_lt_gt", {29'd0, eq, lt, gt}, {29'd0, e.res});
        check("done_cycle", cycle_cnt, e.cyc);
        $display("done: eq=%0b lt=%0b gt=%0b cycle=%0d", eq, lt, gt, cycle_cnt);
      end
    end
  end

  // Called at a negedge; returns just after the capture edge.
  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input bit sv,
                        input logic [2:0] res, input int k, input bit push, input bit keep_start);
    a = av; b = bv; is_signed = sv; start = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      exp_t e;
      e.res = res;
      e.cyc = cycle_cnt + k;
      exp_q.push_back(e);
    end
    if (!keep_start) start = 1'b0;
    $display("start: a=%08h b=%08h signed=%0b expect eq/lt/gt=%03b after %0d", av, bv, sv, res, k);
  endtask

  // Returns at the negedge inside the done cycle.
  task automatic wait_done(input int k, input bit scramble, input bit hold_en, input logic [2:0] hold_v);
    int busy_n = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy === 1'b1) busy_n++;
        if (scramble) begin a = $urandom; b = $urandom; end
        if (hold_en) check("result_hold", {29'd0, eq, lt, gt}, {29'd0, hold_v});
      end
    end
    if (scramble) start = 1'b0;
    check("done_within_bound", {31'd0, seen}, 32'd1);
    check("busy_cycles", busy_n, k);
    check("busy_low_on_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_eq_lt_gt", {29'd0, eq, lt, gt}, 32'd0);
    rst_n = 1'b1;

    // Unsigned equal, full walk.
    @(negedge clk); launch(32'h1234_5678, 32'h1234_5678, 1'b0, 3'b100, 8, 1'b1, 1'b0);
    wait_done(8, 1'b0, 1'b0, 3'b000);

    // Early exit unsigned, then signed flip of the same operands.
    @(negedge clk); launch(32'hF000_0000, 32'h0FFF_FFFF, 1'b0, 3'b001, 1, 1'b1, 1'b0);
    wait_done(1, 1'b0, 1'b0, 3'b000);
    @(negedge clk); launch(32'hF000_0000, 32'h0FFF_FFFF, 1'b1, 3'b010, 1, 1'b1, 1'b0);
    wait_done(1, 1'b0, 1'b0, 3'b000);

    // Signed -1 vs -2: differs only in chunk 0.
    @(negedge clk); launch(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 3'b001, 8, 1'b1, 1'b0);
    wait_done(8, 1'b0, 1'b0, 3'b000);

    // Late difference with operands scrambled and start held during busy.
    @(negedge clk); launch(32'h0000_0003, 32'h0000_0005, 1'b0, 3'b010, 8, 1'b1, 1'b1);
    wait_done(8, 1'b1, 1'b0, 3'b000);
    repeat (2) @(negedge clk);
    check("no_restart_busy", {31'd0, busy}, 32'd0);
    check("result_after_idle", {29'd0, eq, lt, gt}, 32'b010);

    // Back-to-back: gt result, then 7 vs 7 started in its done cycle.
    @(negedge clk); launch(32'hF000_0000, 32'h0FFF_FFFF, 1'b0, 3'b001, 1, 1'b1, 1'b0);
    wait_done(1, 1'b0, 1'b0, 3'b000);
    launch(32'd7, 32'd7, 1'b0, 3'b100, 8, 1'b1, 1'b0);
    check("b2b_accepted_busy", {31'd0, busy}, 32'd1);
    wait_done(8, 1'b0, 1'b1, 3'b001);

    // Reset in the middle of an operation.
    @(negedge clk); launch(32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, 3'b100, 8, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midop_reset_busy", {31'd0, busy}, 32'd0);
    check("midop_reset_done", {31'd0, done}, 32'd0);
    check("midop_reset_eq_lt_gt", {29'd0, eq, lt, gt}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    begin
      int done_seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (done === 1'b1) done_seen++;
      end
      check("no_done_after_reset", done_seen, 0);
    end
    @(negedge clk); launch(32'd1, 32'd2, 1'b0, 3'b010, 8, 1'b1, 1'b0);
    wait_done(8, 1'b0, 1'b0, 3'b000);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
